ncl_sync_capture: RTL and testbench

- Downstream consumer of the NCL dual-rail up-counter output (t_out/f_out, handshake on the counter's ackin).
- Samples the dual-rail word into the clocked domain and performs NULL/DATA completion detection.
- Drives the NCL acknowledge back to the producer.
- Buffers captured words in a small FIFO with a valid/ready interface for synchronous logic.

---
 rtl/ncl_sync_capture.sv | 126 ++++++++++++
 tb/tb_ncl_sync_capture.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ncl_sync_capture.sv
// Clocked-domain consumer for a dual-rail NCL producer: synchronizes the rails,
// detects DATA/NULL completion, drives the acknowledge and buffers words in a FIFO.
module ncl_sync_capture #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         t_in,
    input  logic [WIDTH-1:0]         f_in,
    output logic                     ncl_ack,
    output logic                     m_valid,
    output logic [WIDTH-1:0]         m_data,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         word_cnt,
    output logic                     rail_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        WAIT_DATA = 1'b0,
        WAIT_NULL = 1'b1
    } state_t;

    logic [WIDTH-1:0] t_meta_q, t_sync_q, f_meta_q, f_sync_q;
    state_t           state_q, state_d;
    logic             rail_err_q, rail_err_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem [DEPTH];

    logic complete, is_null, invalid, full, push, pop;

    // Rails only move monotonically between NULL and DATA, so per-bit skew through
    // the two-flop chain shows up as a partial word, never as a wrong one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            t_meta_q <= '0;
            t_sync_q <= '0;
            f_meta_q <= '0;
            f_sync_q <= '0;
        end else begin
            // NOTE: non-blocking, so each stage takes the previous stage's old value.
            t_meta_q <= t_in;
            t_sync_q <= t_meta_q;
            f_meta_q <= f_in;
            f_sync_q <= f_meta_q;
        end
    end

    assign complete = &(t_sync_q ^ f_sync_q);
    assign is_null  = ~|(t_sync_q | f_sync_q);
    assign invalid  = |(t_sync_q & f_sync_q);
    assign full     = (count_q == LVL_FULL);
    assign pop      = (count_q != '0) && m_ready;

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        rail_err_d = rail_err_q;
        push       = 1'b0;
        case (state_q)
            WAIT_DATA: begin
                if (invalid) begin
                    rail_err_d = 1'b1;
                end else if (complete && !full) begin
                    push    = 1'b1;
                    state_d = WAIT_NULL;
                end
            end
            WAIT_NULL: begin
                if (invalid) rail_err_d = 1'b1;
                if (is_null) state_d = WAIT_DATA;
            end
        endcase
    end

    always_comb begin
        word_cnt_d = push ? word_cnt_q + CNT_ONE : word_cnt_q;
        wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop)      count_d = count_q + LVL_ONE;
        else if (!push && pop) count_d = count_q - LVL_ONE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= WAIT_DATA;
            rail_err_q <= 1'b0;
            word_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            rail_err_q <= rail_err_d;
            word_cnt_q <= word_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: storage has no reset; occupancy and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (reset && push) mem[wr_ptr_q] <= t_sync_q;
    end

    assign ncl_ack    = (state_q == WAIT_DATA);
    assign m_valid    = (count_q != '0);
    assign m_data     = mem[rd_ptr_q];
    assign fifo_level = count_q;
    assign word_cnt   = word_cnt_q;
    assign rail_err   = rail_err_q;

endmodule

// File: tb/tb_ncl_sync_capture.sv
// Bench for ncl_sync_capture: a dual-rail producer model drives words, a scoreboard
// queue holds the expected FIFO output order and a monitor checks every pop.
module tb_ncl_sync_capture;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [WIDTH-1:0]       t_in, f_in;
    logic                   ncl_ack;
    logic                   m_valid;
    logic [WIDTH-1:0]       m_data;
    logic                   m_ready;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [CNT_W-1:0]       word_cnt;
    logic                   rail_err;

    int tests = 0;
    int fails = 0;
    int cnt_model = 0;
    logic [WIDTH-1:0] exp_q[$];

    ncl_sync_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .t_in(t_in), .f_in(f_in), .ncl_ack(ncl_ack),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .fifo_level(fifo_level), .word_cnt(word_cnt), .rail_err(rail_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head word must be the oldest outstanding expected word.
    always @(negedge clk) begin
        if (reset === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL pop_unexpected: got %0h expected nothing", m_data);
            end else begin
                check("pop_data", 32'(m_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_data(input logic [WIDTH-1:0] w);
        t_in = w;
        f_in = ~w;
    endtask

    task automatic drive_null();
        t_in = '0;
        f_in = '0;
    endtask

    task automatic wait_ack(input logic val, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (ncl_ack === val) break;
        end
        check(name, 32'(ncl_ack), 32'(val));
    endtask

    // Full four-phase handshake of one word; the word is expected in the FIFO stream.
    task automatic send_word(input logic [WIDTH-1:0] w);
        exp_q.push_back(w);
        cnt_model++;
        drive_data(w);
        wait_ack(1'b0, 40, "hs_ack_fall");
        drive_null();
        wait_ack(1'b1, 40, "hs_ack_rise");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic prod_done;
    logic [WIDTH-1:0] w;

    initial begin
        // Reset with random rails.
        reset = 1'b0;
        m_ready = 1'b0;
        t_in = WIDTH'($urandom);
        f_in = WIDTH'($urandom);
        repeat (3) tick();
        check("rst_ack", 32'(ncl_ack), 32'd1);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_cnt", 32'(word_cnt), 32'd0);
        check("rst_err", 32'(rail_err), 32'd0);
        drive_null();
        tick();
        reset = 1'b1;
        repeat (5) tick();

        // Single word with exact latency.
        m_ready = 1'b1;
        exp_q.push_back(8'h07);
        cnt_model++;
        t_in = 8'h07;
        f_in = 8'hF8;
        repeat (2) tick();
        check("single_ack_early", 32'(ncl_ack), 32'd1);
        tick();
        check("single_ack_fall", 32'(ncl_ack), 32'd0);
        check("single_valid", 32'(m_valid), 32'd1);
        check("single_data", 32'(m_data), 32'h07);
        tick();
        check("single_valid_drop", 32'(m_valid), 32'd0);
        drive_null();
        repeat (2) tick();
        check("null_ack_early", 32'(ncl_ack), 32'd0);
        tick();
        check("null_ack_rise", 32'(ncl_ack), 32'd1);
        check("single_cnt", 32'(word_cnt), 32'd1);

        // Backpressure: fill, hold the fifth word, one pop frees exactly one slot.
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_word(WIDTH'(i));
        check("bp_level_full", 32'(fifo_level), 32'd4);
        exp_q.push_back(8'h05);
        cnt_model++;
        drive_data(8'h05);
        repeat (10) tick();
        check("bp_ack_held", 32'(ncl_ack), 32'd1);
        check("bp_level_held", 32'(fifo_level), 32'd4);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("bp_pop_no_push", 32'(ncl_ack), 32'd1);
        check("bp_level_after_pop", 32'(fifo_level), 32'd3);
        tick();
        check("bp_capture", 32'(ncl_ack), 32'd0);
        check("bp_level_refull", 32'(fifo_level), 32'd4);
        drive_null();
        wait_ack(1'b1, 10, "bp_null");
        m_ready = 1'b1;
        repeat (8) tick();
        check("bp_drained", 32'(exp_q.size()), 32'd0);
        check("bp_level_empty", 32'(fifo_level), 32'd0);

        // Partial word: bit 7 held at NULL.
        w = WIDTH'($urandom);
        t_in = w & 8'h7F;
        f_in = ~w & 8'h7F;
        repeat (20) tick();
        check("partial_ack", 32'(ncl_ack), 32'd1);
        check("partial_cnt", 32'(word_cnt), 32'(cnt_model));
        exp_q.push_back(w);
        cnt_model++;
        drive_data(w);
        repeat (3) tick();
        check("partial_capture", 32'(ncl_ack), 32'd0);
        drive_null();
        wait_ack(1'b1, 10, "partial_null");

        // Invalid rails on bit 3.
        check("err_before", 32'(rail_err), 32'd0);
        w = WIDTH'($urandom);
        t_in = w | 8'h08;
        f_in = ~w | 8'h08;
        repeat (3) tick();
        check("err_set", 32'(rail_err), 32'd1);
        check("err_ack", 32'(ncl_ack), 32'd1);
        check("err_no_write", 32'(fifo_level), 32'd0);
        check("err_cnt", 32'(word_cnt), 32'(cnt_model));
        drive_null();
        repeat (5) tick();
        check("err_sticky", 32'(rail_err), 32'd1);

        // Randomized traffic with random consumer backpressure.
        prod_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) send_word(WIDTH'($urandom));
                prod_done = 1'b1;
            end
            begin
                while (!prod_done) begin
                    tick();
                    m_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        m_ready = 1'b1;
        repeat (10) tick();
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check("rand_cnt", 32'(word_cnt), 32'(cnt_model));
        check("rand_level", 32'(fifo_level), 32'd0);

        // Reset while waiting for NULL with DATA still held.
        m_ready = 1'b0;
        w = WIDTH'($urandom);
        exp_q.push_back(w);
        drive_data(w);
        wait_ack(1'b0, 10, "rw_capture");
        reset = 1'b0;
        tick();
        exp_q.delete();
        cnt_model = 0;
        check("rw_ack", 32'(ncl_ack), 32'd1);
        check("rw_level", 32'(fifo_level), 32'd0);
        check("rw_valid", 32'(m_valid), 32'd0);
        check("rw_err_clear", 32'(rail_err), 32'd0);
        reset = 1'b1;
        exp_q.push_back(w);
        cnt_model++;
        wait_ack(1'b0, 10, "rw_recapture");
        check("rw_cnt", 32'(word_cnt), 32'(cnt_model));
        check("rw_level_one", 32'(fifo_level), 32'd1);
        m_ready = 1'b1;
        drive_null();
        repeat (5) tick();
        check("rw_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
